sram_1rw_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for one single-port 1rw SRAM macro (active-low CSb/WEb/OEb, bidirectional DATA, read data valid DELAY after the clock edge).
- Converts per-requester valid/ready read/write commands into legal SRAM control sequences.
- Owns the tri-state DATA bus and returns captured read data to the issuing requester.
- Sits between client logic and the SRAM macro, one instance per macro.

---
 rtl/sram_1rw_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_1rw_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port 1rw SRAM macro.
// Optional macro SRAM_ARB_WRITE_ACK_EN adds a one-cycle rsp_valid acknowledge after each write.
module sram_1rw_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic                    sram_csb,
  output logic                    sram_web,
  output logic                    sram_oeb,
  inout  wire  [DATA_WIDTH-1:0]   sram_data,
  output logic [1:0]              dbg_state
);

  // Handshake: a command transfers on a posedge where req_valid[i] & req_ready[i];
  // ready is offered only in IDLE and only to the granted requester.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    RD_ISSUE   = 2'd2,
    RD_CAPTURE = 2'd3
  } state_e;

  state_e                  state_q;
  logic                    ptr_q;
  logic                    gnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    drive_q;
  logic                    csb_q;
  logic                    web_q;
  logic                    oeb_q;
  logic [1:0]              rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;

  logic                    gnt_d;
  logic [1:0]              ready_d;
  logic                    hs_d;
  logic                    we_sel;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic [DATA_WIDTH-1:0]   wdata_sel;

  // Grant depends only on valids and the pointer, never on the command fields.
  always_comb begin
    gnt_d   = 1'b0;
    ready_d = 2'b00;
    unique case (req_valid)
      2'b01:   gnt_d = 1'b0;
      2'b10:   gnt_d = 1'b1;
      2'b11:   gnt_d = ptr_q;
      default: gnt_d = 1'b0;
    endcase
    if (state_q == IDLE && req_valid != 2'b00) begin
      ready_d = gnt_d ? 2'b10 : 2'b01;
    end
  end

  assign hs_d      = |(req_valid & ready_d);
  assign we_sel    = gnt_d ? req_we[1] : req_we[0];
  assign addr_sel  = gnt_d ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign wdata_sel = gnt_d ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      oeb_q       <= 1'b1;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (hs_d) begin
            gnt_q   <= gnt_d;
            ptr_q   <= ~gnt_d;
            addr_q  <= addr_sel;
            wdata_q <= wdata_sel;
            csb_q   <= 1'b0;
            if (we_sel) begin
              state_q <= WRITE;
              web_q   <= 1'b0;
              oeb_q   <= 1'b1;
              drive_q <= 1'b1;
            end else begin
              state_q <= RD_ISSUE;
              web_q   <= 1'b1;
              oeb_q   <= 1'b0;
            end
          end
        end
        WRITE: begin
          state_q <= IDLE;
          csb_q   <= 1'b1;
          web_q   <= 1'b1;
          drive_q <= 1'b0;
`ifdef SRAM_ARB_WRITE_ACK_EN
          rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
`endif
        end
        // The SRAM re-reads the same address at the end of this cycle, which is harmless.
        RD_ISSUE: begin
          state_q <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          state_q     <= IDLE;
          csb_q       <= 1'b1;
          oeb_q       <= 1'b1;
          rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
          rsp_rdata_q <= sram_data;
        end
      endcase
    end
  end

  assign sram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign req_ready = ready_d;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sram_addr = addr_q;
  assign sram_csb  = csb_q;
  assign sram_web  = web_q;
  assign sram_oeb  = oeb_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Bench for sram_1rw_arbiter: SRAM macro model, transaction-level reference model
// compared every cycle, and directed scenarios with hand-computed expectations.
module tb_sram_1rw_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [7:0]  sram_addr;
  logic        sram_csb;
  logic        sram_web;
  logic        sram_oeb;
  wire  [7:0]  sram_data;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  sram_1rw_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_csb(sram_csb), .sram_web(sram_web),
    .sram_oeb(sram_oeb), .sram_data(sram_data), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SRAM macro model: read data appears 3 time units after the read edge
  logic [7:0] sram_mem [256];
  logic [7:0] sram_dout = 8'h00;

  always @(posedge clk) begin
    if (!sram_csb && !sram_web) sram_mem[sram_addr] <= sram_data;
    else if (!sram_csb && sram_web) sram_dout <= #3 sram_mem[sram_addr];
  end

  assign sram_data = (!sram_csb && sram_web && !sram_oeb) ? sram_dout : 8'bz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  logic [7:0] m_mem [256];
  int         cyc = 0;
  int         m_left = 0;
  logic       m_ptr = 1'b0;
  logic       m_we = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wdata = 8'h00;
  logic [7:0] m_rdata_exp = 8'h00;
  logic [7:0] m_last_rdata = 8'h00;
  int         due_q[$];
  logic [1:0] mask_q[$];
  logic       isrd_q[$];
  logic [7:0] data_q[$];

  // observation logs used by the directed scenarios
  int         hs_cyc [2];
  int         hs_cnt = 0;
  int         grant_log[$];
  logic [1:0] rsp_mask_log[$];
  logic [7:0] rsp_data_log[$];
  int         last_rsp_cyc = 0;
  int         rsp_cnt = 0;
  int         web_low_cnt = 0;

  // scoreboard / compare process
  always @(negedge clk) begin
    logic [1:0] exp_ready;
    logic [1:0] exp_rv;
    logic [7:0] exp_rd;
    int         g;
    if (rst) begin
      m_left = 0;
      m_ptr = 1'b0;
      m_last_rdata = 8'h00;
      due_q.delete(); mask_q.delete(); isrd_q.delete(); data_q.delete();
      check("rst_ctrl", {sram_csb, sram_web, sram_oeb}, 3'b111);
      check("rst_rsp_valid", rsp_valid, 2'b00);
      check("rst_rsp_rdata", rsp_rdata, 8'h00);
    end else begin
      if (!sram_web) web_low_cnt++;
      check("bus_owner", {sram_web, sram_oeb} == 2'b00, 1'b0);
      if (m_left > 0) begin
        check("ctrl_busy", {sram_csb, sram_web, sram_oeb}, m_we ? 3'b001 : 3'b010);
        check("sram_addr", sram_addr, m_addr);
        if (m_we) check("bus_wdata", sram_data, m_wdata);
        else if (m_left == 1) check("bus_rdata", sram_data, m_rdata_exp);
      end else begin
        check("ctrl_idle", {sram_csb, sram_web, sram_oeb}, 3'b111);
      end

      exp_rv = 2'b00;
      exp_rd = m_last_rdata;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        exp_rv = mask_q[0];
        if (isrd_q[0]) begin
          exp_rd = data_q[0];
          m_last_rdata = data_q[0];
        end
        void'(due_q.pop_front()); void'(mask_q.pop_front());
        void'(isrd_q.pop_front()); void'(data_q.pop_front());
      end
      check("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv != 2'b00) check("rsp_rdata", rsp_rdata, exp_rd);
      if (rsp_valid != 2'b00) begin
        rsp_mask_log.push_back(rsp_valid);
        rsp_data_log.push_back(rsp_rdata);
        last_rsp_cyc = cyc;
        rsp_cnt++;
      end

      exp_ready = 2'b00;
      g = 0;
      if (m_left == 0 && req_valid != 2'b00) begin
        g = (req_valid == 2'b11) ? int'(m_ptr) : (req_valid[1] ? 1 : 0);
        exp_ready = (g == 1) ? 2'b10 : 2'b01;
      end
      check("req_ready", req_ready, exp_ready);
      if (m_left > 0) m_left--;
      if ((exp_ready & req_valid) != 2'b00) begin
        m_ptr = (g == 0);
        m_we = req_we[g];
        m_addr = req_addr[g*8 +: 8];
        m_wdata = req_wdata[g*8 +: 8];
        hs_cyc[g] = cyc;
        hs_cnt++;
        grant_log.push_back(g);
        if (m_we) begin
          m_mem[m_addr] = m_wdata;
          m_left = 1;
`ifdef SRAM_ARB_WRITE_ACK_EN
          due_q.push_back(cyc + 2); mask_q.push_back(exp_ready);
          isrd_q.push_back(1'b0); data_q.push_back(8'h00);
`endif
        end else begin
          m_rdata_exp = m_mem[m_addr];
          m_left = 2;
          due_q.push_back(cyc + 3); mask_q.push_back(exp_ready);
          isrd_q.push_back(1'b1); data_q.push_back(m_mem[m_addr]);
        end
      end
    end
    cyc++;
  end

  // driver tasks
  task automatic issue(input int r, input logic we, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    req_we[r] = we;
    req_addr[r*8 +: 8] = a;
    req_wdata[r*8 +: 8] = d;
    req_valid[r] = 1'b1;
    @(negedge clk); #1;
    while (!req_ready[r] && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("issue_timeout", n < 50, 1'b1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    sram_mem[a] = d;
    m_mem[a] = d;
  endtask

  initial begin
    int start_hs;
    int n;
    int web_snap;
    int rsp_snap;
    rst = 1'b1;
    req_valid = 2'b00;
    req_we = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 256; i++) preload(i[7:0], 8'h00);
    preload(8'h10, 8'h11);
    preload(8'h20, 8'h22);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);

    // reset during RD_CAPTURE abandons the read
    issue(0, 1'b0, 8'h10, 8'h00);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_ctrl", {sram_csb, sram_web, sram_oeb}, 3'b111);
    check("async_rst_rsp", rsp_valid, 2'b00);
    rsp_snap = rsp_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(4);
    check("rst_no_response", rsp_cnt, rsp_snap);

    // contention: both valid, reads alternate starting with r0
    grant_log.delete(); rsp_mask_log.delete(); rsp_data_log.delete();
    start_hs = hs_cnt;
    req_we = 2'b00;
    req_addr = {8'h20, 8'h10};
    req_valid = 2'b11;
    n = 0;
    while (hs_cnt - start_hs < 4 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check("contention_timeout", n < 40, 1'b1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_cycles(6);
    check("rr_count", grant_log.size(), 4);
    check("rr_rsp_count", rsp_data_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) check("rr_grant", grant_log[i], i % 2);
      if (i < rsp_data_log.size()) begin
        check("rr_rsp_mask", rsp_mask_log[i], (i % 2) ? 2'b10 : 2'b01);
        check("rr_rsp_data", rsp_data_log[i], (i % 2) ? 8'h22 : 8'h11);
      end
    end

    // single requester write then read
    issue(0, 1'b1, 8'h3C, 8'hA5);
    issue(0, 1'b0, 8'h3C, 8'h00);
    wait_cycles(5);
    check("wr_sram_cell", sram_mem[8'h3C], 8'hA5);
    check("rd_latency", last_rsp_cyc - hs_cyc[0], 3);
    check("rd_mask", rsp_mask_log[$], 2'b01);
    check("rd_data", rsp_data_log[$], 8'hA5);

    // boundary addresses
    issue(0, 1'b1, 8'hFF, 8'hFF);
    issue(1, 1'b1, 8'h00, 8'h00);
    issue(0, 1'b0, 8'hFF, 8'h00);
    wait_cycles(4);
    check("bnd_ff_mask", rsp_mask_log[$], 2'b01);
    check("bnd_ff_data", rsp_data_log[$], 8'hFF);
    issue(1, 1'b0, 8'h00, 8'h00);
    wait_cycles(4);
    check("bnd_00_mask", rsp_mask_log[$], 2'b10);
    check("bnd_00_data", rsp_data_log[$], 8'h00);

    // back-to-back: r1 write then r0 read of the same word
    web_snap = web_low_cnt;
    issue(1, 1'b1, 8'h80, 8'h5A);
    issue(0, 1'b0, 8'h80, 8'h00);
    wait_cycles(5);
    check("b2b_gap", hs_cyc[0] - hs_cyc[1], 2);
    check("b2b_web_low", web_low_cnt - web_snap, 1);
    check("b2b_data", rsp_data_log[$], 8'h5A);

    // write acknowledge behaviour
    rsp_snap = rsp_cnt;
    issue(1, 1'b1, 8'h01, 8'h77);
    wait_cycles(4);
`ifdef SRAM_ARB_WRITE_ACK_EN
    check("wack_count", rsp_cnt - rsp_snap, 1);
    check("wack_mask", rsp_mask_log[$], 2'b10);
    check("wack_latency", last_rsp_cyc - hs_cyc[1], 2);
    check("wack_rdata_held", rsp_data_log[$], 8'h5A);
`else
    check("no_wack", rsp_cnt - rsp_snap, 0);
`endif
    check("wack_sram_cell", sram_mem[8'h01], 8'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
